dec_trigger_pipe: RTL
=====================

# dec_trigger_pipe

Carries per-instruction trigger match vectors from decode (D) to writeback (WB) alongside the i0/i1 instruction slots. It resolves trigger chaining and i0/i1 priority, then presents the final trigger hits and the required action to the TLU at WB. It also maintains the sticky per-trigger hit bits reported through tdata1. It sits directly downstream of the decode-stage PC trigger comparators and upstream of the TLU trap/debug logic.

## Interface
Parameters:
- NUM_TRIG, 4, number of triggers; chain pairs are (0,1) and (2,3).
- DEPTH, 4, register stages from D to WB (E1, E2, E3, WB).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- dec_i0_trigger_match_d  in  NUM_TRIG  raw i0 matches in D.
- dec_i1_trigger_match_d  in  NUM_TRIG  raw i1 matches in D.
- dec_i0_valid_d  in  1  i0 issues from D this cycle.
- dec_i1_valid_d  in  1  i1 issues from D this cycle.
- trig_chain  in  NUM_TRIG/2  bit k set: pair (2k, 2k+1) is chained.
- trig_action  in  NUM_TRIG  per trigger: 1 = enter debug mode, 0 = breakpoint exception.
- dec_pipe_stall  in  1  hold all stages; D does not advance.
- dec_tlu_flush_lower  in  1  kill all in-flight entries, D included.
- trig_hit_clr  in  NUM_TRIG  CSR write clears the matching sticky hit bits.
- dec_tlu_i0_trigger_wb  out  NUM_TRIG  final i0 hits at WB.
- dec_tlu_i1_trigger_wb  out  NUM_TRIG  final i1 hits at WB.
- dec_tlu_trigger_debug_wb  out  1  a WB hit requests debug entry.
- dec_tlu_trigger_excp_wb  out  1  a WB hit requests a breakpoint exception.
- trig_hit_sticky  out  NUM_TRIG  sticky hit bits.

## Operation
- **Entry (D→E1).** Entry mask for slot s = match_s & {NUM_TRIG{valid_s}}.
- **Chain resolution (D→E1).** Applied when chain bit k is set. Bits 2k and 2k+1 both become (m[2k] & m[2k+1]): a pair fires only when both triggers match the same instruction. Unchained bits pass through unchanged.
- **Advance and stall.**
  - Each stage holds {i0_vec, i1_vec}, and each stage is valid iff its vector is non-zero.
  - No stall: every stage advances by one per cycle.
  - dec_pipe_stall=1: every stage holds, and D entries are not captured.
- **Flush.** dec_tlu_flush_lower=1 zeroes E1..WB next cycle and discards the D inputs. Flush has priority over stall and over entry.
- **i0/i1 priority (E3→WB).** If the final i0 vector is non-zero, the i1 vector is forced to 0. The i1 instruction is younger and is squashed by the i0 trap.
- **Action at WB.** F = wb_i0 | wb_i1.
  - debug_wb = |(F & trig_action).
  - excp_wb = |F & ~debug_wb.
  - When both kinds of action are hit, debug wins.
- **Sticky bits.** Each cycle with !dec_pipe_stall, trig_hit_sticky |= F. Then trig_hit_clr bits clear. If set and clear coincide on the same bit, set wins.
- **Outputs.** WB outputs are register outputs and stay asserted while the WB stage is stalled.

## Timing
- Reset values: all stage vectors, all WB outputs, and trig_hit_sticky are 0.
- Latency: a match sampled in D at cycle t appears at WB at cycle t+DEPTH with no stalls. Each stall cycle adds one cycle.
- Chain evaluation and priority are combinational between register stages. All outputs are registered and have no combinational path from inputs.
- Reset asserted mid-operation clears everything on the next edge. This is identical to a flush plus a sticky clear.
- Sticky update takes effect the cycle after WB presents F.
- Back-to-back hits in consecutive instructions produce consecutive WB pulses with no bubble.

## Structure
- Shared package swerv_types: NUM_TRIG, TRIG_PIPE_DEPTH, and a trig_vec_t typedef (logic [NUM_TRIG-1:0]).
- One sub-module, dec_trigger_stage: a parameterised register for {i0_vec, i1_vec} with hold (stall) and synchronous clear (flush/rst). It is instantiated DEPTH times.
- Chain, priority and action logic stays in the top module.

## Test plan
- **Single hit, action=0.** Input i0 match=4'b0001 with valid_d=1 and no stall. Expected: dec_tlu_i0_trigger_wb=4'b0001 4 cycles later, excp_wb=1, debug_wb=0; trig_hit_sticky=4'b0001 one cycle after that.
- **Chaining.** Set trig_chain=2'b01 and send i0 match=4'b0001. Expected: nothing reaches WB. Then send match=4'b0011. Expected: WB=4'b0011.
- **i0/i1 priority and debug-over-exception.** Send i0=4'b0100 and i1=4'b1000 in the same cycle, with trig_action=4'b0100. Expected: i0_wb=4'b0100, i1_wb=4'b0000, debug_wb=1, excp_wb=0.
- **Stall.** Hit entered at t, with dec_pipe_stall held for 2 cycles mid-pipe. Expected: WB at t+6, held high through any WB stall, then cleared after advance.
- **Flush.** Entries in E1 and E3 with dec_tlu_flush_lower=1 and stall=1 in the same cycle. Expected: all WB outputs stay 0 and the sticky bits are unchanged.
- **Sticky clear collision.** trig_hit_clr=4'b0001 in the same cycle F=4'b0001. Expected: sticky stays 1. Next cycle, clr=4'b0001 with no hit. Expected: sticky=0.

Source files
------------

// File: rtl/swerv_types.sv
// Shared types and sizing for the decode trigger pipeline.
//   NUM_TRIG        : number of debug triggers (chain pairs are (0,1), (2,3), ...)
//   TRIG_PIPE_DEPTH : register stages from D to WB (E1, E2, E3, WB)
//   trig_vec_t      : one bit per trigger
package swerv_types;

  localparam int unsigned NUM_TRIG        = 4;
  localparam int unsigned TRIG_PIPE_DEPTH = 4;

  typedef logic [NUM_TRIG-1:0] trig_vec_t;

endpackage

// File: rtl/dec_trigger_stage.sv
// One pipeline register holding the {i0, i1} trigger vectors of a stage.
//   clk_i  : core clock
//   rst_i  : synchronous active-high reset
//   hold_i : keep current contents (pipeline stall)
//   clr_i  : synchronous clear (flush); wins over hold
//   i0_d_i / i1_d_i : next-stage vectors
//   i0_q_o / i1_q_o : registered vectors
module dec_trigger_stage
  import swerv_types::*;
#(
  parameter int unsigned Width = NUM_TRIG
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             clr_i,
  input  logic [Width-1:0] i0_d_i,
  input  logic [Width-1:0] i1_d_i,
  output logic [Width-1:0] i0_q_o,
  output logic [Width-1:0] i1_q_o
);

  logic [Width-1:0] i0_q, i1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      i0_q <= '0;
      i1_q <= '0;
    end else if (!hold_i) begin
      i0_q <= i0_d_i;
      i1_q <= i1_d_i;
    end
  end

  assign i0_q_o = i0_q;
  assign i1_q_o = i1_q;

endmodule

// File: rtl/dec_trigger_pipe.sv
// Carries per-instruction trigger matches from D to WB, resolves chaining and
// i0/i1 priority, and presents registered hits plus the required action to the TLU.
//   clk, rst (sync, active-high)
//   dec_i0/i1_trigger_match_d, dec_i0/i1_valid_d : raw D-stage matches and issue valids
//   trig_chain  : bit k chains pair (2k, 2k+1)
//   trig_action : per trigger, 1 = debug entry, 0 = breakpoint exception
//   dec_pipe_stall, dec_tlu_flush_lower : hold / kill all stages (flush wins)
//   trig_hit_clr : clears sticky hit bits (a same-cycle hit wins)
//   dec_tlu_i0/i1_trigger_wb, dec_tlu_trigger_debug_wb/excp_wb : registered WB results
//   trig_hit_sticky : sticky hit bits
module dec_trigger_pipe
  import swerv_types::*;
#(
  parameter int unsigned NUM_TRIG = swerv_types::NUM_TRIG,
  parameter int unsigned DEPTH    = TRIG_PIPE_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_TRIG-1:0]   dec_i0_trigger_match_d,
  input  logic [NUM_TRIG-1:0]   dec_i1_trigger_match_d,
  input  logic                  dec_i0_valid_d,
  input  logic                  dec_i1_valid_d,
  input  logic [NUM_TRIG/2-1:0] trig_chain,
  input  logic [NUM_TRIG-1:0]   trig_action,
  input  logic                  dec_pipe_stall,
  input  logic                  dec_tlu_flush_lower,
  input  logic [NUM_TRIG-1:0]   trig_hit_clr,
  output logic [NUM_TRIG-1:0]   dec_tlu_i0_trigger_wb,
  output logic [NUM_TRIG-1:0]   dec_tlu_i1_trigger_wb,
  output logic                  dec_tlu_trigger_debug_wb,
  output logic                  dec_tlu_trigger_excp_wb,
  output logic [NUM_TRIG-1:0]   trig_hit_sticky
);

  logic [NUM_TRIG-1:0] i0_ent, i1_ent;
  logic [NUM_TRIG-1:0] stg_i0 [DEPTH];
  logic [NUM_TRIG-1:0] stg_i1 [DEPTH];
  logic [NUM_TRIG-1:0] wb_i1_d, wb_f_d, wb_f;
  logic                debug_d, excp_d, debug_q, excp_q;
  logic [NUM_TRIG-1:0] sticky_d, sticky_q;

  // Entry masking and chain resolution: a chained pair fires only when both
  // triggers match the same instruction.
  always_comb begin
    i0_ent = dec_i0_trigger_match_d & {NUM_TRIG{dec_i0_valid_d}};
    i1_ent = dec_i1_trigger_match_d & {NUM_TRIG{dec_i1_valid_d}};
    for (int k = 0; k < int'(NUM_TRIG / 2); k++) begin
      if (trig_chain[k]) begin
        i0_ent[2*k]   = i0_ent[2*k] & i0_ent[2*k+1];
        i0_ent[2*k+1] = i0_ent[2*k];
        i1_ent[2*k]   = i1_ent[2*k] & i1_ent[2*k+1];
        i1_ent[2*k+1] = i1_ent[2*k];
      end
    end
  end

  // i1 is younger: any i0 hit entering WB squashes it.
  always_comb begin
    wb_i1_d = (|stg_i0[DEPTH-2]) ? '0 : stg_i1[DEPTH-2];
    wb_f_d  = stg_i0[DEPTH-2] | wb_i1_d;
    debug_d = |(wb_f_d & trig_action);
    excp_d  = (|wb_f_d) & ~debug_d;
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    logic [NUM_TRIG-1:0] nxt_i0, nxt_i1;

    if (s == 0) begin : g_first
      assign nxt_i0 = i0_ent;
      assign nxt_i1 = i1_ent;
    end else if (s == DEPTH - 1) begin : g_wb
      assign nxt_i0 = stg_i0[s-1];
      assign nxt_i1 = wb_i1_d;
    end else begin : g_mid
      assign nxt_i0 = stg_i0[s-1];
      assign nxt_i1 = stg_i1[s-1];
    end

    dec_trigger_stage #(
      .Width (NUM_TRIG)
    ) u_stage (
      .clk_i  (clk),
      .rst_i  (rst),
      .hold_i (dec_pipe_stall),
      .clr_i  (dec_tlu_flush_lower),
      .i0_d_i (nxt_i0),
      .i1_d_i (nxt_i1),
      .i0_q_o (stg_i0[s]),
      .i1_q_o (stg_i1[s])
    );
  end

  // Action bits travel with the WB stage so they hold under stall.
  always_ff @(posedge clk) begin
    if (rst || dec_tlu_flush_lower) begin
      debug_q <= 1'b0;
      excp_q  <= 1'b0;
    end else if (!dec_pipe_stall) begin
      debug_q <= debug_d;
      excp_q  <= excp_d;
    end
  end

  assign wb_f = stg_i0[DEPTH-1] | stg_i1[DEPTH-1];

  // Clear first, then set, so a coincident hit wins.
  always_comb begin
    sticky_d = sticky_q & ~trig_hit_clr;
    if (!dec_pipe_stall) begin
      sticky_d = sticky_d | wb_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign dec_tlu_i0_trigger_wb    = stg_i0[DEPTH-1];
  assign dec_tlu_i1_trigger_wb    = stg_i1[DEPTH-1];
  assign dec_tlu_trigger_debug_wb = debug_q;
  assign dec_tlu_trigger_excp_wb  = excp_q;
  assign trig_hit_sticky          = sticky_q;

endmodule
